// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// mem_stage_ctrl
//   MEM-stage controller for a 5-stage pipeline. Turns the EX/MEM control and
//   data outputs into a single-outstanding data-memory request, stalls the
//   front of the pipeline while that request is in flight, resolves the branch
//   redirect, and owns the MEM/WB pipeline register.
//
//   FSM: IDLE -> (access) -> REQ -> (i_dm_ready) -> DONE -> IDLE
//     IDLE : non-access instructions flow straight into MEM/WB. An access
//            raises o_stall combinationally, latches the request and inserts
//            a MEM/WB bubble.
//     REQ  : o_dm_req held high from a register until i_dm_ready. The read
//            data is captured on the ready cycle.
//     DONE : the held instruction retires into MEM/WB with the captured read
//            data, then the FSM returns to IDLE without reissuing it.
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   i_ctrl_*                  EX/MEM control bits
//   i_data_*                  EX/MEM data, flags and destination register
//   o_dm_req/we/addr/wdata    data-memory request (word aligned address)
//   i_dm_ready, i_dm_rdata    data-memory completion and read data
//   o_stall                   hold PC, IF/ID, ID/EX and EX/MEM
//   o_PCSrc, o_PCBranch       branch redirect
//   o_WB_*                    MEM/WB register outputs
//   o_exc_ovf                 overflow trap pulse (MEM_OVF_TRAP_EN only)
//
// Build option
//   MEM_OVF_TRAP_EN : when defined, an instruction with i_data_Overflow=1 is
//   squashed (no memory access, RegWrite cleared) and o_exc_ovf pulses for
//   one clock. When undefined, o_exc_ovf does not exist and the overflow
//   flag is ignored.
// ============================================================================
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        nrst,
`ifdef MEM_OVF_TRAP_EN
    output logic        o_exc_ovf,
`endif
    input  logic        i_ctrl_MemRead,
    input  logic        i_ctrl_MemWrite,
    input  logic        i_ctrl_Branch,
    input  logic        i_ctrl_Mem2Reg,
    input  logic        i_ctrl_RegWrite,
    input  logic [31:0] i_data_ALUOut,
    input  logic [31:0] i_data_RTData,
    input  logic [31:0] i_data_PCBranch,
    input  logic        i_data_Zero,
    input  logic        i_data_Overflow,
    input  logic [4:0]  i_data_RegAddrW,
    output logic        o_dm_req,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic        i_dm_ready,
    input  logic [31:0] i_dm_rdata,
    output logic        o_stall,
    output logic        o_PCSrc,
    output logic [31:0] o_PCBranch,
    output logic        o_WB_ctrl_Mem2Reg,
    output logic        o_WB_ctrl_RegWrite,
    output logic [31:0] o_WB_data_MemData,
    output logic [31:0] o_WB_data_ALUOut,
    output logic [4:0]  o_WB_data_RegAddrW
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_next;

    logic        w_ovf;
    logic        w_access;
    logic        w_stall;
    logic        w_start;      // IDLE -> REQ: latch the request
    logic        w_capture;    // REQ ready cycle: capture read data
    logic        w_bubble;     // load an empty MEM/WB slot

    logic        r_dm_req;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic        r_is_read;    // read-only access; read+write counts as a write
    logic [31:0] r_rdata;

    logic        r_wb_mem2reg;
    logic        r_wb_regwrite;
    logic [31:0] r_wb_memdata;
    logic [31:0] r_wb_aluout;
    logic [4:0]  r_wb_regaddrw;

`ifdef MEM_OVF_TRAP_EN
    logic        r_exc_ovf;
    assign w_ovf     = i_data_Overflow;
    assign o_exc_ovf = r_exc_ovf;
`else
    logic        w_unused_ovf;
    assign w_ovf        = 1'b0;
    assign w_unused_ovf = i_data_Overflow;
`endif

    // A trapped instruction never touches memory.
    assign w_access = (i_ctrl_MemRead | i_ctrl_MemWrite) & ~w_ovf;

    // ------------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_bubble  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_stall  = 1'b1;
                    w_start  = 1'b1;
                    w_bubble = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (i_dm_ready) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                // EX/MEM advances on this edge, so the held instruction is
                // retired here and never re-examined.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ------------------------------------------------------------------------
    // Memory request registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= 32'd0;
            r_dm_wdata <= 32'd0;
            r_is_read  <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            if (w_start) begin
                r_dm_req   <= 1'b1;
                r_dm_we    <= i_ctrl_MemWrite;
                r_dm_addr  <= {i_data_ALUOut[31:2], 2'b00};
                r_dm_wdata <= i_data_RTData;
                r_is_read  <= i_ctrl_MemRead & ~i_ctrl_MemWrite;
            end else if (w_capture) begin
                r_dm_req <= 1'b0;
                r_dm_we  <= 1'b0;
                r_rdata  <= i_dm_rdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wb_mem2reg  <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memdata  <= 32'd0;
            r_wb_aluout   <= 32'd0;
            r_wb_regaddrw <= 5'd0;
        end else if (w_bubble) begin
            r_wb_mem2reg  <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memdata  <= 32'd0;
            r_wb_aluout   <= 32'd0;
            r_wb_regaddrw <= 5'd0;
        end else begin
            r_wb_mem2reg  <= i_ctrl_Mem2Reg;
            r_wb_regwrite <= i_ctrl_RegWrite & ~w_ovf;
            r_wb_memdata  <= ((r_state == S_DONE) && r_is_read) ? r_rdata : 32'd0;
            r_wb_aluout   <= i_data_ALUOut;
            r_wb_regaddrw <= i_data_RegAddrW;
        end
    end

`ifdef MEM_OVF_TRAP_EN
    // Trap is only taken when the instruction is first seen in IDLE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_exc_ovf <= 1'b0;
        else       r_exc_ovf <= (r_state == S_IDLE) & w_ovf;
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_stall            = w_stall;
    assign o_dm_req           = r_dm_req;
    assign o_dm_we            = r_dm_we;
    assign o_dm_addr          = r_dm_addr;
    assign o_dm_wdata         = r_dm_wdata;
    assign o_PCSrc            = i_ctrl_Branch & i_data_Zero;
    assign o_PCBranch         = i_data_PCBranch;
    assign o_WB_ctrl_Mem2Reg  = r_wb_mem2reg;
    assign o_WB_ctrl_RegWrite = r_wb_regwrite;
    assign o_WB_data_MemData  = r_wb_memdata;
    assign o_WB_data_ALUOut   = r_wb_aluout;
    assign o_WB_data_RegAddrW = r_wb_regaddrw;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// tb_mem_stage_ctrl
//   Directed scenarios followed by a random instruction stream. Each
//   instruction is modelled as a transaction: the expected cycle-by-cycle
//   stall/request timeline and the final MEM/WB contents are derived from the
//   instruction fields and the chosen memory wait count.
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_ctrl_MemRead, i_ctrl_MemWrite, i_ctrl_Branch;
    logic        i_ctrl_Mem2Reg, i_ctrl_RegWrite;
    logic [31:0] i_data_ALUOut, i_data_RTData, i_data_PCBranch;
    logic        i_data_Zero, i_data_Overflow;
    logic [4:0]  i_data_RegAddrW;
    logic        o_dm_req, o_dm_we;
    logic [31:0] o_dm_addr, o_dm_wdata;
    logic        i_dm_ready;
    logic [31:0] i_dm_rdata;
    logic        o_stall, o_PCSrc;
    logic [31:0] o_PCBranch;
    logic        o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite;
    logic [31:0] o_WB_data_MemData, o_WB_data_ALUOut;
    logic [4:0]  o_WB_data_RegAddrW;
`ifdef MEM_OVF_TRAP_EN
    logic        o_exc_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk                (clk),
        .nrst               (nrst),
`ifdef MEM_OVF_TRAP_EN
        .o_exc_ovf          (o_exc_ovf),
`endif
        .i_ctrl_MemRead     (i_ctrl_MemRead),
        .i_ctrl_MemWrite    (i_ctrl_MemWrite),
        .i_ctrl_Branch      (i_ctrl_Branch),
        .i_ctrl_Mem2Reg     (i_ctrl_Mem2Reg),
        .i_ctrl_RegWrite    (i_ctrl_RegWrite),
        .i_data_ALUOut      (i_data_ALUOut),
        .i_data_RTData      (i_data_RTData),
        .i_data_PCBranch    (i_data_PCBranch),
        .i_data_Zero        (i_data_Zero),
        .i_data_Overflow    (i_data_Overflow),
        .i_data_RegAddrW    (i_data_RegAddrW),
        .o_dm_req           (o_dm_req),
        .o_dm_we            (o_dm_we),
        .o_dm_addr          (o_dm_addr),
        .o_dm_wdata         (o_dm_wdata),
        .i_dm_ready         (i_dm_ready),
        .i_dm_rdata         (i_dm_rdata),
        .o_stall            (o_stall),
        .o_PCSrc            (o_PCSrc),
        .o_PCBranch         (o_PCBranch),
        .o_WB_ctrl_Mem2Reg  (o_WB_ctrl_Mem2Reg),
        .o_WB_ctrl_RegWrite (o_WB_ctrl_RegWrite),
        .o_WB_data_MemData  (o_WB_data_MemData),
        .o_WB_data_ALUOut   (o_WB_data_ALUOut),
        .o_WB_data_RegAddrW (o_WB_data_RegAddrW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic m2r, input logic rw,
                          input logic [31:0] md, input logic [31:0] alu, input logic [4:0] ra);
        chk({tag, ".Mem2Reg"},  o_WB_ctrl_Mem2Reg,  m2r);
        chk({tag, ".RegWrite"}, o_WB_ctrl_RegWrite, rw);
        chk({tag, ".MemData"},  o_WB_data_MemData,  md);
        chk({tag, ".ALUOut"},   o_WB_data_ALUOut,   alu);
        chk({tag, ".RegAddrW"}, o_WB_data_RegAddrW, ra);
    endtask

    task automatic clear_inputs();
        i_ctrl_MemRead = 0; i_ctrl_MemWrite = 0; i_ctrl_Branch = 0;
        i_ctrl_Mem2Reg = 0; i_ctrl_RegWrite = 0;
        i_data_ALUOut = 0; i_data_RTData = 0; i_data_PCBranch = 0;
        i_data_Zero = 0; i_data_Overflow = 0; i_data_RegAddrW = 0;
        i_dm_ready = 0; i_dm_rdata = 0;
    endtask

    // One instruction, presented after a falling edge and held while the
    // model says the stage is stalled. w = extra REQ cycles before ready.
    task automatic run_instr(input logic rd, input logic wr, input logic br, input logic zr,
                             input logic m2r, input logic rw, input logic ovf,
                             input logic [31:0] alu, input logic [31:0] rt,
                             input logic [31:0] pcb, input logic [4:0] ra, input int w);
        logic        trap, acc;
        logic [31:0] cap;
`ifdef MEM_OVF_TRAP_EN
        trap = ovf;
`else
        trap = 1'b0;
`endif
        acc = (rd | wr) & ~trap;
        cap = 32'd0;

        @(negedge clk);
        i_ctrl_MemRead = rd; i_ctrl_MemWrite = wr; i_ctrl_Branch = br;
        i_ctrl_Mem2Reg = m2r; i_ctrl_RegWrite = rw;
        i_data_ALUOut = alu; i_data_RTData = rt; i_data_PCBranch = pcb;
        i_data_Zero = zr; i_data_Overflow = ovf; i_data_RegAddrW = ra;
        i_dm_ready = 1'($urandom_range(0, 1));   // must be ignored in IDLE
        i_dm_rdata = $urandom;
        #1;
        chk("pcsrc",    o_PCSrc,    br & zr);
        chk("pcbranch", o_PCBranch, pcb);
        chk("stall_p",  o_stall,    acc);
        chk("req_p",    o_dm_req,   1'b0);
        chk("we_p",     o_dm_we,    1'b0);
        @(posedge clk); #1;
`ifdef MEM_OVF_TRAP_EN
        chk("exc_ovf", o_exc_ovf, trap);
`endif
        if (!acc) begin
            chk_wb("wb_pass", m2r, rw & ~trap, 32'd0, alu, ra);
            return;
        end
        chk("bub_rw",  o_WB_ctrl_RegWrite, 1'b0);
        chk("bub_m2r", o_WB_ctrl_Mem2Reg,  1'b0);

        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            i_dm_ready = (k == w);
            i_dm_rdata = $urandom;
            if (k == w) cap = i_dm_rdata;
            #1;
            chk("stall_req", o_stall,   1'b1);
            chk("dm_req",    o_dm_req,  1'b1);
            chk("dm_we",     o_dm_we,   wr);
            chk("dm_addr",   o_dm_addr, {alu[31:2], 2'b00});
            if (wr) chk("dm_wdata", o_dm_wdata, rt);
            @(posedge clk); #1;
            chk("bub_rw",  o_WB_ctrl_RegWrite, 1'b0);
            chk("bub_m2r", o_WB_ctrl_Mem2Reg,  1'b0);
        end

        @(negedge clk);
        i_dm_ready = 1'($urandom_range(0, 1));   // must be ignored in DONE
        i_dm_rdata = $urandom;
        #1;
        chk("stall_done", o_stall,  1'b0);
        chk("req_done",   o_dm_req, 1'b0);
        chk("we_done",    o_dm_we,  1'b0);
        @(posedge clk); #1;
        chk_wb("wb_mem", m2r, rw, (rd && !wr) ? cap : 32'd0, alu, ra);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        clear_inputs();
        #12;
        chk("rst_stall", o_stall,  1'b0);
        chk("rst_req",   o_dm_req, 1'b0);
        chk("rst_we",    o_dm_we,  1'b0);
        chk("rst_addr",  o_dm_addr, 32'd0);
        chk_wb("rst_wb", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        nrst = 1'b1;

        // ALU op straight through
        run_instr(0,0,0,0, 0,1,0, 32'h1234, 32'h0, 32'h0, 5'd5, 0);
        chk("alu_stall_after", o_stall, 1'b0);

        // reset clears a populated MEM/WB immediately
        #2 nrst = 1'b0;
        #1 chk_wb("rst_wb2", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk) nrst = 1'b1;

        // Load with ready on the 3rd REQ cycle, misaligned address
        run_instr(1,0,0,0, 1,1,0, 32'h103, 32'h0, 32'h0, 5'd9, 2);
        // Store, ready immediately
        run_instr(0,1,0,0, 0,0,0, 32'h20, 32'hA5A5A5A5, 32'h0, 5'd0, 0);
        // Read+write together behaves as a write
        run_instr(1,1,0,0, 1,1,0, 32'h8F, 32'h0BADF00D, 32'h0, 5'd3, 1);
        // Branch taken / not taken
        run_instr(0,0,1,1, 0,0,0, 32'h0, 32'h0, 32'h400, 5'd0, 0);
        run_instr(0,0,1,0, 0,0,0, 32'h0, 32'h0, 32'h400, 5'd0, 0);

        // Reset during REQ aborts the access
        @(negedge clk);
        i_ctrl_MemRead = 1; i_ctrl_Mem2Reg = 1; i_ctrl_RegWrite = 1;
        i_data_ALUOut = 32'h44; i_dm_ready = 0;
        @(posedge clk); #1;
        chk("pre_rst_req", o_dm_req, 1'b1);
        #2;
        nrst = 1'b0;
        clear_inputs();
        #1;
        chk("abort_req",   o_dm_req,  1'b0);
        chk("abort_we",    o_dm_we,   1'b0);
        chk("abort_stall", o_stall,   1'b0);
        chk("abort_addr",  o_dm_addr, 32'd0);
        chk_wb("abort_wb", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        nrst = 1'b1;

        // First instruction after reset is handled from IDLE
        run_instr(1,0,0,0, 1,1,0, 32'h200, 32'h0, 32'h0, 5'd7, 0);

`ifdef MEM_OVF_TRAP_EN
        // Overflowing load: squashed, trap pulses one clock
        run_instr(1,0,0,0, 1,1,1, 32'h300, 32'h0, 32'h0, 5'd4, 0);
        run_instr(0,0,0,0, 0,1,0, 32'h55, 32'h0, 32'h0, 5'd2, 0);
`endif

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            logic ovf_r;
`ifdef MEM_OVF_TRAP_EN
            ovf_r = ($urandom_range(0, 7) == 0);
`else
            ovf_r = 1'($urandom_range(0, 1));
`endif
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ovf_r,
                      $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                      int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
